x_micro_sequencer_p: RTL and testbench
======================================

X_MICRO_SEQUENCER_P -- requirements
Module: x_micro_sequencer_p

Interface
REQ-001 SHALL have parameter DATA_W, default 36, instruction operand and output width (8..64).
REQ-002 SHALL have parameter ADDR_W, default 9, program address width; program depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter LOOP_W, default 16, loop counter width (LOOP_W <= DATA_W).
REQ-004 SHALL have port i_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port i_start  input  1  start-program pulse; sampled only in IDLE.
REQ-007 SHALL have port o_busy  output  1  high while the program runs.
REQ-008 SHALL have port o_done  output  1  one-cycle pulse when HALT executes.
REQ-009 SHALL have port i_wen  input  1  program-memory write enable.
REQ-010 SHALL have port i_wcmd  input  4  opcode to write.
REQ-011 SHALL have port i_wdata  input  DATA_W  operand to write.
REQ-012 SHALL have port i_waddr  input  ADDR_W  program write address.
REQ-013 SHALL have port o_data  output  DATA_W  registered sequencer output.

Function
REQ-014 SHALL store DEPTH entries of {cmd[3:0], operand[DATA_W-1:0]} in a synchronous-read memory with one-cycle read latency.
REQ-015 SHALL accept a write only when i_wen=1 and state is IDLE; writes while busy are ignored.
REQ-016 SHALL use states IDLE, FETCH, EXEC, WAIT.
REQ-017 SHALL, in IDLE with i_start=1, set pc=0 and enter FETCH; o_busy=1 from the next cycle.
REQ-018 SHALL, if i_wen and i_start coincide in IDLE, commit the write first so the first fetch sees it.
REQ-019 SHALL issue the read of pc in FETCH and decode the returned word in EXEC (2 cycles per instruction minimum).
REQ-020 SHALL implement opcodes: 0 HALT, 1 SET, 2 WAIT, 3 JMP, 4 LDC, 5 DJNZ; 6..15 act as NOP (pc+1).
REQ-021 SHALL on SET load o_data<=operand, pc<=pc+1, go FETCH.
REQ-022 SHALL on WAIT with operand n>0 stay in WAIT exactly n extra cycles, then pc+1, FETCH; n=0 behaves as NOP.
REQ-023 SHALL on JMP set pc<=operand[ADDR_W-1:0], go FETCH.
REQ-024 SHALL on LDC load loop counter<=operand[LOOP_W-1:0], pc+1.
REQ-025 SHALL on DJNZ decrement loop counter; if result nonzero pc<=operand[ADDR_W-1:0] else pc+1; counter 0 on entry wraps to all-ones and jumps.
REQ-026 SHALL on HALT pulse o_done for one cycle, drop o_busy in the same cycle, go IDLE, hold o_data.
REQ-027 SHALL wrap pc from DEPTH-1 to 0 on increment.
REQ-028 SHALL ignore i_start while busy.
REQ-029 SHALL keep o_data unchanged except on SET or reset.

Reset
REQ-030 SHALL on i_rst=1 force state IDLE, pc=0, loop counter=0, o_busy=0, o_done=0, o_data=0, dominating all other inputs including mid-program.
REQ-031 SHALL NOT clear program memory on reset; contents persist across reset.

Structure
REQ-032 SHALL place opcode enum, state enum and opcode width constant in package x_micro_sequencer_pkg.
REQ-033 SHALL place the program memory in sub-module x_micro_sequencer_mem (parameters DATA_W+4, ADDR_W; one write port, one registered read port).

Verification
REQ-034 SHALL check: write {SET 0x5A, HALT} at 0,1; pulse start -> o_busy high next cycle, o_data=0x5A after SET's EXEC, o_done pulse, total busy 4 cycles.
REQ-035 SHALL check: {WAIT 10, HALT} -> busy lasts 2+10+2=14 cycles, o_data unchanged.
REQ-036 SHALL check: {LDC 3, SET 1, DJNZ 1, HALT} -> SET executes 3 times, single o_done, o_data=1.
REQ-037 SHALL check: ADDR_W=4, SET at 15 then HALT at 0 via wrap from JMP 15 -> o_data set, done pulse.
REQ-038 SHALL check: assert i_rst mid-WAIT -> next cycle o_busy=0, o_data=0, memory contents unchanged on re-run.
REQ-039 SHALL check: write to addr 0 and start while busy are ignored; write+start in same IDLE cycle uses new word.

Source files
------------

// File: rtl/x_micro_sequencer_pkg.sv
// Shared definitions for the micro-sequencer.
//   OPC_W    : opcode field width in each program word
//   opcode_e : instruction opcodes (6..15 are unnamed and execute as NOP)
//   state_e  : sequencer control states
package x_micro_sequencer_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_HALT = 4'd0,
        OP_SET  = 4'd1,
        OP_WAIT = 4'd2,
        OP_JMP  = 4'd3,
        OP_LDC  = 4'd4,
        OP_DJNZ = 4'd5
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT
    } state_e;

endpackage

// File: rtl/x_micro_sequencer_mem.sv
// Program store: one write port, one registered read port (1-cycle latency).
// Contents are never cleared by reset.
//   clk   : clock
//   we    : write enable, waddr/wdata : write address/word
//   re    : read enable,  raddr       : read address
//   rdata : word read on the previous enabled cycle
module x_micro_sequencer_mem #(
    parameter int WIDTH  = 40,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/x_micro_sequencer_p.sv
// Small programmable sequencer: runs a program of {cmd, operand} words from
// an internal memory and drives a registered output word.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_start               : start pulse (honoured only when idle)
//   o_busy, o_done        : running flag, one-cycle HALT pulse
//   i_wen/i_wcmd/i_wdata/i_waddr : program write port (idle only)
//   o_data                : output word, changed only by SET and reset
module x_micro_sequencer_p
    import x_micro_sequencer_pkg::*;
#(
    parameter int DATA_W = 36,
    parameter int ADDR_W = 9,
    parameter int LOOP_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    input  logic              i_wen,
    input  logic [3:0]        i_wcmd,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_waddr,
    output logic [DATA_W-1:0] o_data
);

    localparam int WORD_W = DATA_W + OPC_W;

    state_e              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_inc;
    logic [LOOP_W-1:0]   loop_cnt, loop_dec;
    logic [DATA_W-1:0]   wait_cnt;
    logic [WORD_W-1:0]   rd_word;
    opcode_e             cmd;
    logic [DATA_W-1:0]   operand;
    logic                mem_we;

    // Writes only land while idle; a write coinciding with start commits on
    // the same edge, so the first FETCH one cycle later reads it back.
    assign mem_we  = i_wen && (state == S_IDLE);
    assign cmd     = opcode_e'(rd_word[WORD_W-1:DATA_W]);
    assign operand = rd_word[DATA_W-1:0];
    assign pc_inc  = pc + ADDR_W'(1);
    assign loop_dec = loop_cnt - LOOP_W'(1);

    x_micro_sequencer_mem #(
        .WIDTH  (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (i_clk),
        .we    (mem_we),
        .waddr (i_waddr),
        .wdata ({i_wcmd, i_wdata}),
        .re    (state == S_FETCH),
        .raddr (pc),
        .rdata (rd_word)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC: begin
                case (cmd)
                    OP_HALT: state_nxt = S_IDLE;
                    OP_WAIT: state_nxt = (operand != '0) ? S_WAIT : S_FETCH;
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_WAIT:  if (wait_cnt == DATA_W'(1)) state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs: busy is simply "not idle", so it falls in the same cycle the
    // registered done pulse rises.
    always_comb begin
        o_busy = (state != S_IDLE);
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc       <= '0;
            loop_cnt <= '0;
            wait_cnt <= '0;
            o_data   <= '0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: if (i_start) pc <= '0;
                S_EXEC: begin
                    case (cmd)
                        OP_HALT: o_done <= 1'b1;
                        OP_SET: begin
                            o_data <= operand;
                            pc     <= pc_inc;
                        end
                        OP_WAIT: begin
                            if (operand == '0) pc <= pc_inc;
                            else               wait_cnt <= operand;
                        end
                        OP_JMP:  pc <= operand[ADDR_W-1:0];
                        OP_LDC: begin
                            loop_cnt <= operand[LOOP_W-1:0];
                            pc       <= pc_inc;
                        end
                        // A zero counter wraps to all-ones, hence jumps.
                        OP_DJNZ: begin
                            loop_cnt <= loop_dec;
                            pc       <= (loop_dec != '0) ? operand[ADDR_W-1:0] : pc_inc;
                        end
                        default: pc <= pc_inc;
                    endcase
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - DATA_W'(1);
                    if (wait_cnt == DATA_W'(1)) pc <= pc_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_x_micro_sequencer_p.sv
module tb_x_micro_sequencer_p;

    logic        clk;
    logic        rst;
    logic        a_start, a_wen;
    logic [3:0]  a_wcmd;
    logic [35:0] a_wdata;
    logic [8:0]  a_waddr;
    logic        a_busy, a_done;
    logic [35:0] a_data;

    logic        b_start, b_wen;
    logic [3:0]  b_wcmd;
    logic [35:0] b_wdata;
    logic [3:0]  b_waddr;
    logic        b_busy, b_done;
    logic [35:0] b_data;

    int tests = 0;
    int fails = 0;

    // Reference model state (program image, output word, loop counter)
    logic [3:0]  m_cmd [512];
    logic [35:0] m_op  [512];
    logic [35:0] m_data;
    logic [15:0] m_lc;

    x_micro_sequencer_p dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .o_busy(a_busy), .o_done(a_done),
        .i_wen(a_wen), .i_wcmd(a_wcmd), .i_wdata(a_wdata), .i_waddr(a_waddr), .o_data(a_data)
    );

    x_micro_sequencer_p #(.ADDR_W(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .o_busy(b_busy), .o_done(b_done),
        .i_wen(b_wen), .i_wcmd(b_wcmd), .i_wdata(b_wdata), .i_waddr(b_waddr), .o_data(b_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction-level model: each instruction costs 2 cycles, WAIT n adds n.
    task automatic model_run(output int cyc);
        int pc = 0;
        cyc = 0;
        for (int s = 0; s < 100000; s++) begin
            logic [3:0]  c = m_cmd[pc];
            logic [35:0] op = m_op[pc];
            cyc += 2;
            if (c == 4'd0) break;
            case (c)
                4'd1: begin m_data = op; pc = pc + 1; end
                4'd2: begin cyc += int'(op); pc = pc + 1; end
                4'd3: pc = int'(op[8:0]);
                4'd4: begin m_lc = op[15:0]; pc = pc + 1; end
                4'd5: begin
                    m_lc = m_lc - 16'd1;
                    pc = (m_lc != 0) ? int'(op[8:0]) : pc + 1;
                end
                default: pc = pc + 1;
            endcase
            pc = pc % 512;
        end
    endtask

    // All tasks are entered and left just after a falling edge.
    task automatic wr_a(input int addr, input logic [3:0] c, input logic [35:0] op);
        a_wen = 1'b1; a_waddr = 9'(addr); a_wcmd = c; a_wdata = op;
        @(negedge clk);
        a_wen = 1'b0;
        m_cmd[addr] = c;
        m_op[addr]  = op;
    endtask

    task automatic wr_b(input int addr, input logic [3:0] c, input logic [35:0] op);
        b_wen = 1'b1; b_waddr = 4'(addr); b_wcmd = c; b_wdata = op;
        @(negedge clk);
        b_wen = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_data = '0;
        m_lc   = '0;
    endtask

    // Start a program on dut_a and count busy cycles / done pulses.
    // poke: write addr 0 and re-pulse start while busy (must be ignored).
    // wr_start: write SET w_op at addr 0 in the same cycle as start.
    task automatic run_a(input bit poke, input bit wr_start, input logic [35:0] w_op,
                         output int busy_c, output int done_c,
                         output logic first_busy, output logic [35:0] data2);
        a_start = 1'b1;
        if (wr_start) begin
            a_wen = 1'b1; a_waddr = '0; a_wcmd = 4'd1; a_wdata = w_op;
            m_cmd[0] = 4'd1; m_op[0] = w_op;
        end
        @(negedge clk);
        a_start = 1'b0; a_wen = 1'b0;
        busy_c = 0; done_c = 0; data2 = '0;
        first_busy = a_busy;
        for (int i = 0; i < 5000; i++) begin
            if (a_done) done_c++;
            if (!a_busy) break;
            busy_c++;
            if (i == 2) data2 = a_data;
            if (poke && i == 1) begin
                a_wen = 1'b1; a_waddr = '0; a_wcmd = 4'd1; a_wdata = 36'h77; a_start = 1'b1;
            end else begin
                a_wen = 1'b0; a_start = 1'b0;
            end
            @(negedge clk);
        end
        a_wen = 1'b0; a_start = 1'b0;
        check("run_a_finished", a_busy, 0);
        @(negedge clk);
        check("done_one_cycle", a_done, 0);
    endtask

    task automatic run_b(output int busy_c, output int done_c);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        busy_c = 0; done_c = 0;
        for (int i = 0; i < 5000; i++) begin
            if (b_done) done_c++;
            if (!b_busy) break;
            busy_c++;
            @(negedge clk);
        end
        check("run_b_finished", b_busy, 0);
    endtask

    initial begin
        int bc, dc, mc, addr, k;
        logic fb;
        logic [35:0] d2, r;

        rst = 1'b1;
        a_start = 0; a_wen = 0; a_wcmd = 0; a_wdata = 0; a_waddr = 0;
        b_start = 0; b_wen = 0; b_wcmd = 0; b_wdata = 0; b_waddr = 0;
        m_data = '0; m_lc = '0;
        for (int i = 0; i < 512; i++) begin m_cmd[i] = 0; m_op[i] = 0; end
        repeat (3) @(negedge clk);
        check("rst_busy_a", a_busy, 0);
        check("rst_done_a", a_done, 0);
        check("rst_data_a", a_data, 0);
        check("rst_busy_b", b_busy, 0);
        check("rst_data_b", b_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // SET 0x5A; HALT
        wr_a(0, 4'd1, 36'h5A);
        wr_a(1, 4'd0, 36'h0);
        run_a(0, 0, '0, bc, dc, fb, d2);
        check("set_busy_next", fb, 1);
        check("set_data_after_exec", d2, 36'h5A);
        check("set_busy_cycles", bc, 4);
        check("set_done_count", dc, 1);
        check("set_data_final", a_data, 36'h5A);
        model_run(mc);

        // WAIT 10; HALT
        wr_a(0, 4'd2, 36'd10);
        run_a(0, 0, '0, bc, dc, fb, d2);
        check("wait_busy_cycles", bc, 14);
        check("wait_data_held", a_data, 36'h5A);
        check("wait_done_count", dc, 1);
        model_run(mc);

        // LDC 3; SET 1; DJNZ 1; HALT -- SET runs three times
        wr_a(0, 4'd4, 36'd3);
        wr_a(1, 4'd1, 36'd1);
        wr_a(2, 4'd5, 36'd1);
        wr_a(3, 4'd0, 36'd0);
        run_a(0, 0, '0, bc, dc, fb, d2);
        check("loop_busy_cycles", bc, 2 + 3 * 4 + 2);
        check("loop_done_count", dc, 1);
        check("loop_data", a_data, 36'd1);
        model_run(mc);

        // Reset in the middle of a WAIT
        wr_a(0, 4'd2, 36'd10);
        wr_a(1, 4'd0, 36'd0);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", a_busy, 0);
        check("midrst_data", a_data, 0);
        check("midrst_done", a_done, 0);
        rst = 1'b0;
        m_data = '0; m_lc = '0;
        @(negedge clk);
        run_a(0, 0, '0, bc, dc, fb, d2);
        model_run(mc);
        check("midrst_rerun_busy", bc, mc);
        check("midrst_rerun_done", dc, 1);
        check("midrst_rerun_data", a_data, m_data);

        // Writes and start while busy are ignored
        wr_a(0, 4'd1, 36'h11);
        wr_a(1, 4'd2, 36'd5);
        wr_a(2, 4'd0, 36'd0);
        run_a(1, 0, '0, bc, dc, fb, d2);
        model_run(mc);
        check("busywr_busy", bc, 11);
        check("busywr_done", dc, 1);
        check("busywr_data", a_data, 36'h11);
        do_reset();
        run_a(0, 0, '0, bc, dc, fb, d2);
        check("busywr_mem_kept", a_data, 36'h11);
        model_run(mc);

        // Write and start in the same idle cycle
        run_a(0, 1, 36'h33, bc, dc, fb, d2);
        model_run(mc);
        check("wrstart_data", a_data, 36'h33);
        check("wrstart_busy", bc, mc);

        // Small program memory: SET at 15, wrap back to 0
        wr_b(0, 4'd4, 36'd2);
        wr_b(1, 4'd0, 36'd0);
        run_b(bc, dc);
        check("wrap_ldc_busy", bc, 4);
        wr_b(0, 4'd5, 36'd15);
        wr_b(15, 4'd1, 36'hAB);
        run_b(bc, dc);
        check("wrap_busy", bc, 8);
        check("wrap_done", dc, 1);
        check("wrap_data", b_data, 36'hAB);

        // Randomised straight-line/loop/jump programs against the model
        for (int t = 0; t < 20; t++) begin
            addr = 0;
            for (int blk = 0; blk < int'($urandom_range(2, 5)); blk++) begin
                r = 36'({$urandom(), $urandom()});
                case ($urandom_range(0, 4))
                    0: begin wr_a(addr, 4'd1, r); addr += 1; end
                    1: begin wr_a(addr, 4'd2, 36'($urandom_range(0, 5))); addr += 1; end
                    2: begin wr_a(addr, 4'($urandom_range(6, 15)), r); addr += 1; end
                    3: begin
                        k = int'($urandom_range(1, 3));
                        wr_a(addr, 4'd4, 36'(k));
                        wr_a(addr + 1, 4'd1, r);
                        wr_a(addr + 2, 4'd5, 36'(addr + 1));
                        addr += 3;
                    end
                    default: begin
                        wr_a(addr, 4'd3, 36'(addr + 2));
                        wr_a(addr + 1, 4'd1, 36'hDEAD);
                        addr += 2;
                    end
                endcase
            end
            wr_a(addr, 4'd0, 36'd0);
            run_a(0, 0, '0, bc, dc, fb, d2);
            model_run(mc);
            check("rand_busy", bc, mc);
            check("rand_done", dc, 1);
            check("rand_data", a_data, m_data);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
